// File: rtl/conv_mac_feeder.sv
// conv_mac_feeder
//   Drives a pipelined MAC to compute a valid (no-padding) 1-D convolution
//   y[j] = sum_k x[j+k]*w[k], j = 0..N-M.
//   Filter taps and then input samples arrive over a valid/ready load
//   stream. For each output point the MAC accumulator is cleared, M tap
//   products are issued back to back, and the accumulated value is captured
//   when the M-th MAC valid_out returns. The MAC latency is not assumed;
//   only the returned valid_out pulses are counted.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   s_data/s_valid/s_ready load stream (M taps first, then N samples)
//   mac_reset             MAC reset / accumulator clear
//   a, b, valid_in        MAC operands (sample, tap) and their valid
//   mac_f, mac_valid_out  MAC accumulator output and its valid
//   y, y_valid            convolution result, one-cycle pulse
//   done                  one-cycle pulse after the last result
module conv_mac_feeder #(
  parameter int WIDTH = 14,
  parameter int N     = 8,
  parameter int M     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      mac_reset,
  output logic signed [WIDTH-1:0]   a,
  output logic signed [WIDTH-1:0]   b,
  output logic                      valid_in,
  input  logic [2*WIDTH-1:0]        mac_f,
  input  logic                      mac_valid_out,
  output logic signed [2*WIDTH-1:0] y,
  output logic                      y_valid,
  output logic                      done
);

  localparam int IW = $clog2(N + 1);

  typedef enum logic [2:0] {
    LOAD_W, LOAD_X, CLEAR, ISSUE, DRAIN, OUTPUT, DONE
  } state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] w [M];
  logic signed [WIDTH-1:0] x [N];
  logic [IW-1:0]           ld_cnt, j, k, ret_cnt;
  logic                    xfer;
  logic [IW-1:0]           k_nxt, w_idx, x_idx;
  logic signed [WIDTH-1:0] a_nxt, b_nxt;

  assign xfer  = s_valid & s_ready;
  assign k_nxt = k + IW'(1);

  // Operand select for the cycle being set up: tap 0 when leaving CLEAR,
  // otherwise the next tap within ISSUE.
  assign w_idx = (state == CLEAR) ? '0 : k_nxt;
  assign x_idx = j + w_idx;

  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < N; i++)
      if (x_idx == IW'(i)) a_nxt = x[i];
    for (int i = 0; i < M; i++)
      if (w_idx == IW'(i)) b_nxt = w[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_W;
      ld_cnt    <= '0;
      j         <= '0;
      k         <= '0;
      ret_cnt   <= '0;
      s_ready   <= 1'b0;
      mac_reset <= 1'b1;
      valid_in  <= 1'b0;
      a         <= '0;
      b         <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < M; i++) w[i] <= '0;
      for (int i = 0; i < N; i++) x[i] <= '0;
    end else begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      // Returns are only meaningful while our own products are in flight.
      if ((state == ISSUE || state == DRAIN) && mac_valid_out)
        ret_cnt <= ret_cnt + IW'(1);

      case (state)
        LOAD_W: begin
          s_ready   <= 1'b1;
          mac_reset <= 1'b0;
          if (xfer) begin
            for (int i = 0; i < M; i++)
              if (ld_cnt == IW'(i)) w[i] <= s_data;
            if (ld_cnt == IW'(M - 1)) begin
              ld_cnt <= '0;
              state  <= LOAD_X;
            end else begin
              ld_cnt <= ld_cnt + IW'(1);
            end
          end
        end
        LOAD_X: begin
          if (xfer) begin
            for (int i = 0; i < N; i++)
              if (ld_cnt == IW'(i)) x[i] <= s_data;
            if (ld_cnt == IW'(N - 1)) begin
              ld_cnt    <= '0;
              s_ready   <= 1'b0;
              j         <= '0;
              mac_reset <= 1'b1;
              ret_cnt   <= '0;
              state     <= CLEAR;
            end else begin
              ld_cnt <= ld_cnt + IW'(1);
            end
          end
        end
        CLEAR: begin
          mac_reset <= 1'b0;
          valid_in  <= 1'b1;
          a         <= a_nxt;
          b         <= b_nxt;
          k         <= '0;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (k == IW'(M - 1)) begin
            valid_in <= 1'b0;
            state    <= DRAIN;
          end else begin
            k <= k_nxt;
            a <= a_nxt;
            b <= b_nxt;
          end
        end
        DRAIN: begin
          // The M-th return carries the finished accumulation.
          if (mac_valid_out && ret_cnt == IW'(M - 1)) begin
            y       <= mac_f;
            y_valid <= 1'b1;
            state   <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (j == IW'(N - M)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            j         <= j + IW'(1);
            mac_reset <= 1'b1;
            ret_cnt   <= '0;
            state     <= CLEAR;
          end
        end
        DONE: begin
          s_ready <= 1'b1;
          state   <= LOAD_W;
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_feeder.sv
module tb_conv_mac_feeder;

  localparam int W = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- main DUT (N=8, M=3) ----------------
  logic signed [W-1:0]   s_data = '0;
  logic                  s_valid = 1'b0;
  logic                  s_ready, mac_reset, valid_in, y_valid, done;
  logic signed [W-1:0]   a, b;
  logic [2*W-1:0]        mac_f;
  logic                  mac_valid_out;
  logic signed [2*W-1:0] y;

  conv_mac_feeder #(.WIDTH(W), .N(8), .M(3)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mac_reset(mac_reset), .a(a), .b(b),
    .valid_in(valid_in), .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .y(y), .y_valid(y_valid), .done(done)
  );

  // MAC model with runtime-selectable latency
  int                    mac_lat = 5;
  logic                  inj_en = 1'b0;
  logic                  pv [0:7];
  logic signed [2*W-1:0] pp [0:7];
  logic [2*W-1:0]        acc;
  logic                  mvo;

  always @(posedge clk) begin
    if (mac_reset) begin
      for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
      acc <= '0;
      mvo <= 1'b0;
    end else begin
      pv[0] <= valid_in;
      pp[0] <= a * b;
      for (int i = 1; i < 8; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
      end
      mvo <= pv[mac_lat-2];
      if (pv[mac_lat-2]) acc <= acc + pp[mac_lat-2];
    end
  end

  assign mac_f         = acc;
  assign mac_valid_out = mvo | (inj_en & s_ready);

  // ---------------- M=N=3 DUT ----------------
  logic signed [W-1:0]   s_data2 = '0;
  logic                  s_valid2 = 1'b0;
  logic                  s_ready2, mac_reset2, valid_in2, y_valid2, done2;
  logic signed [W-1:0]   a2, b2;
  logic [2*W-1:0]        mac_f2;
  logic                  mac_valid_out2;
  logic signed [2*W-1:0] y2;

  conv_mac_feeder #(.WIDTH(W), .N(3), .M(3)) dut2 (
    .clk(clk), .reset(reset), .s_data(s_data2), .s_valid(s_valid2),
    .s_ready(s_ready2), .mac_reset(mac_reset2), .a(a2), .b(b2),
    .valid_in(valid_in2), .mac_f(mac_f2), .mac_valid_out(mac_valid_out2),
    .y(y2), .y_valid(y_valid2), .done(done2)
  );

  logic                  pv2 [0:3];
  logic signed [2*W-1:0] pp2 [0:3];
  logic [2*W-1:0]        acc2;
  logic                  mvo2;

  always @(posedge clk) begin
    if (mac_reset2) begin
      for (int i = 0; i < 4; i++) pv2[i] <= 1'b0;
      acc2 <= '0;
      mvo2 <= 1'b0;
    end else begin
      pv2[0] <= valid_in2;
      pp2[0] <= a2 * b2;
      for (int i = 1; i < 4; i++) begin
        pv2[i] <= pv2[i-1];
        pp2[i] <= pp2[i-1];
      end
      mvo2 <= pv2[3];
      if (pv2[3]) acc2 <= acc2 + pp2[3];
    end
  end

  assign mac_f2         = acc2;
  assign mac_valid_out2 = mvo2;

  // ---------------- monitors ----------------
  logic [2*W-1:0] exp_q [$];
  logic [2*W-1:0] exp_y;
  logic signed [W-1:0] iss_a [$];
  logic signed [W-1:0] iss_b [$];
  int   y_cnt = 0, mrst_cnt = 0, seq_err = 0;
  logic prev_vi = 1'b0, prev_mr = 1'b0, prev_rst = 1'b1;

  // Scoreboard: every y_valid pops one expected result.
  always @(negedge clk) begin
    if (!reset && y_valid) begin
      y_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL y_unexpected: got y=%0d with no result expected", y);
      end else begin
        exp_y = exp_q.pop_front();
        if (y !== exp_y) begin
          errors++;
          $display("FAIL y_value: got %0d (0x%h) expected %0d (0x%h)",
                   y, y, exp_y, exp_y);
        end
      end
    end
    if (!reset && valid_in) begin
      iss_a.push_back(a);
      iss_b.push_back(b);
    end
    if (!reset && mac_reset) mrst_cnt++;
    // each issue group must be preceded directly by a single clear cycle
    if (!reset && valid_in && !prev_vi && !prev_mr) seq_err++;
    if (!reset && !prev_rst && mac_reset && prev_mr) seq_err++;
    prev_vi  = valid_in;
    prev_mr  = mac_reset;
    prev_rst = reset;
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic load_words(input int words[$], input bit gaps, output int cyc);
    int  idx = 0;
    bit  rdy;
    cyc = 0;
    while (idx < words.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      s_data  = W'(words[idx]);
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy     = s_ready;
      @(posedge clk);
      if (s_valid && rdy) idx++;
    end
  endtask

  task automatic run_conv(input int wq[$], input int xq[$], input bit gaps,
                          input bit junk, output int cyc, output bit to,
                          output bit sr_bad);
    int  words[$];
    bit  done_seen = 0;
    for (int jj = 0; jj <= xq.size() - wq.size(); jj++) begin
      logic [2*W-1:0] s = '0;
      for (int kk = 0; kk < wq.size(); kk++)
        s = s + (2*W)'(wq[kk] * xq[jj+kk]);
      exp_q.push_back(s);
    end
    words  = {wq, xq};
    sr_bad = 0;
    load_words(words, gaps, cyc);
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      s_valid = junk;
      s_data  = 14'h1555;
      if (s_ready !== 1'b0) sr_bad = 1;
      if (done === 1'b1) begin
        done_seen = 1;
        s_valid   = 1'b0;
      end
    end
    s_valid = 1'b0;
    to = !done_seen;
  endtask

  int basic_w[$] = '{1, 2, 3};
  int basic_x[$] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int cyc_lat5 = 0;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || valid_in !== 1'b0 || a !== '0 || b !== '0 ||
        y !== '0 || y_valid !== 1'b0 || done !== 1'b0 || mac_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: s_ready=%b valid_in=%b a=%0d b=%0d y=%0d y_valid=%b done=%b mac_reset=%b, expected 0,0,0,0,0,0,0,1",
               s_ready, valid_in, a, b, y, y_valid, done, mac_reset);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || mac_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b mac_reset=%b expected 1,0", s_ready, mac_reset);
    end
  endtask

  task automatic test_basic();
    int cyc; bit to, sr_bad;
    y_cnt = 0; mrst_cnt = 0; seq_err = 0;
    iss_a.delete(); iss_b.delete();
    run_conv(basic_w, basic_x, 0, 0, cyc, to, sr_bad);
    cyc_lat5 = cyc;
    checks++;
    if (to || y_cnt != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_count: timeout=%b y_count=%0d left=%0d expected 0,6,0", to, y_cnt, exp_q.size());
    end
    checks++;
    if (iss_a.size() != 18 || mrst_cnt != 6 || seq_err != 0) begin
      errors++;
      $display("FAIL basic_issue: issues=%0d clears=%0d seq_err=%0d expected 18,6,0", iss_a.size(), mrst_cnt, seq_err);
    end
    checks++;
    if (iss_a.size() < 6 || iss_a[3] !== 14'sd2 || iss_a[5] !== 14'sd4 || iss_b[4] !== 14'sd2 || iss_b[5] !== 14'sd3) begin
      errors++;
      $display("FAIL basic_operands: got a3=%0d a5=%0d b4=%0d b5=%0d expected 2,4,2,3",
               iss_a.size() > 5 ? iss_a[3] : 0, iss_a.size() > 5 ? iss_a[5] : 0,
               iss_b.size() > 5 ? iss_b[4] : 0, iss_b.size() > 5 ? iss_b[5] : 0);
    end
  endtask

  task automatic test_signed();
    int cyc; bit to, sr_bad; int bad = 0;
    int wq[$] = '{-8192, -8192, -8192};
    int xq[$] = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
    y_cnt = 0;
    iss_a.delete(); iss_b.delete();
    run_conv(wq, xq, 0, 0, cyc, to, sr_bad);
    checks++;
    if (to || y_cnt != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL signed_count: timeout=%b y_count=%0d expected 0,6", to, y_cnt);
    end
    for (int i = 0; i < iss_a.size(); i++)
      if (iss_a[i][W-1] !== 1'b1 || iss_b[i][W-1] !== 1'b1 || iss_a[i] !== -14'sd8192 || iss_b[i] !== -14'sd8192) bad++;
    checks++;
    if (bad != 0 || iss_a.size() != 18) begin
      errors++;
      $display("FAIL signed_operands: bad=%0d issues=%0d expected 0,18", bad, iss_a.size());
    end
  endtask

  task automatic test_load_gaps();
    int cyc; bit to, sr_bad;
    y_cnt = 0;
    inj_en = 1'b1;
    run_conv(basic_w, basic_x, 1, 1, cyc, to, sr_bad);
    inj_en = 1'b0;
    checks++;
    if (to || y_cnt != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps_count: timeout=%b y_count=%0d left=%0d expected 0,6,0", to, y_cnt, exp_q.size());
    end
    checks++;
    if (sr_bad) begin
      errors++;
      $display("FAIL gaps_sready: s_ready=1 seen between last load and done, expected 0");
    end
  endtask

  task automatic test_latency();
    int cyc; bit to, sr_bad;
    y_cnt = 0;
    mac_lat = 7;
    run_conv(basic_w, basic_x, 0, 0, cyc, to, sr_bad);
    mac_lat = 5;
    checks++;
    if (to || y_cnt != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL latency_count: timeout=%b y_count=%0d expected 0,6", to, y_cnt);
    end
    checks++;
    if (cyc - cyc_lat5 != 12) begin
      errors++;
      $display("FAIL latency_spacing: extra cycles=%0d expected 12", cyc - cyc_lat5);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to, sr_bad; int n = 0; int words[$];
    y_cnt = 0;
    exp_q.push_back(28'd14);
    exp_q.push_back(28'd20);
    words = {basic_w, basic_x};
    load_words(words, 0, cyc);
    @(negedge clk);
    s_valid = 1'b0;
    while (!(y_cnt == 2 && valid_in === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL midreset_reach: third issue group never seen");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || valid_in !== 1'b0 || a !== '0 || b !== '0 ||
        y !== '0 || y_valid !== 1'b0 || done !== 1'b0 || mac_reset !== 1'b1) begin
      errors++;
      $display("FAIL midreset_values: s_ready=%b valid_in=%b a=%0d b=%0d y=%0d y_valid=%b done=%b mac_reset=%b",
               s_ready, valid_in, a, b, y, y_valid, done, mac_reset);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || y_cnt != 2) begin
      errors++;
      $display("FAIL midreset_idle: s_ready=%b y_count=%0d expected 1,2", s_ready, y_cnt);
    end
    y_cnt = 0;
    run_conv(basic_w, basic_x, 0, 0, cyc, to, sr_bad);
    checks++;
    if (to || y_cnt != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_rerun: timeout=%b y_count=%0d expected 0,6", to, y_cnt);
    end
  endtask

  task automatic test_m_eq_n();
    int words[$] = '{1, 1, 1, 2, 3, 4};
    int idx = 0, cyc = 0, ny = 0;
    bit rdy, done_seen = 0;
    logic [2*W-1:0] got = '0;
    while (idx < words.size() && cyc < 500) begin
      @(negedge clk);
      cyc++;
      s_data2  = W'(words[idx]);
      s_valid2 = 1'b1;
      rdy      = s_ready2;
      @(posedge clk);
      if (s_valid2 && rdy) idx++;
    end
    @(negedge clk);
    s_valid2 = 1'b0;
    while (!done_seen && cyc < 500) begin
      if (y_valid2) begin ny++; got = y2; end
      if (done2) done_seen = 1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done_seen || ny != 1) begin
      errors++;
      $display("FAIL mn_count: done=%b y_count=%0d expected 1,1", done_seen, ny);
    end
    checks++;
    if (got !== 28'd9) begin
      errors++;
      $display("FAIL mn_value: got %0d expected 9", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_load_gaps();
    test_latency();
    test_reset_mid();
    test_m_eq_n();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
